// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared owner-state type, requester ids and default widths
// for the BRAM port arbiter and its read-tag pipe.
package bram_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_ENG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } ownerState_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of {valid, id} tags that follows
// each issued BRAM read until its data appears on the BRAM output.
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_in,
    input  logic i_push,
    input  logic i_pushId,
    output logic o_headValid,
    output logic o_tailValid,
    output logic o_tailId
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_id;

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_valid <= '0;
            r_id    <= {DEPTH{REQ_HOST}};
        end else begin
            r_valid[0] <= i_push;
            r_id[0]    <= i_pushId;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign o_headValid = r_valid[0];
    assign o_tailValid = r_valid[DEPTH-1];
    assign o_tailId    = r_id[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between the host packet controller
// (requester 0) and the processing engine (requester 1), with locked bursts,
// forced release after MAX_BURST beats and read-data steering by tag.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin contests; when it is
// undefined requester 0 has fixed priority.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic              bram_regce,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    localparam int               CNT_W         = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(MAX_BURST);
    localparam logic             BURST_ALLOWED = (MAX_BURST > 1);

    ownerState_t       r_state;
    ownerState_t       w_nextState;
    logic [CNT_W-1:0]  r_beatCnt;
    logic [CNT_W-1:0]  w_nextBeatCnt;
    logic              r_portId;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_anyGnt;
    logic              w_gntId;
    logic              w_gntLock;
    logic              w_gntWe;
    logic [ADDR_W-1:0] w_gntAddr;
    logic [DATA_W-1:0] w_gntWdata;
    logic              w_contestId;

    logic              w_headValid;
    logic              w_tagValid;
    logic              w_tagId;

`ifdef ARB_ROUND_ROBIN_EN
    logic              r_lastGnt;

    // Remember who was granted last so a contest goes to the other side.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_lastGnt <= REQ_ENG;
        end else if (w_anyGnt) begin
            r_lastGnt <= w_gntId;
        end
    end

    assign w_contestId = ~r_lastGnt;
`else
    assign w_contestId = REQ_HOST;
`endif

    // Owner state and beat counter register.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state   <= IDLE;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_beatCnt <= w_nextBeatCnt;
        end
    end

    // Next owner: lock claims the port, unlock/drop/MAX_BURST releases it.
    always_comb begin
        w_nextState   = r_state;
        w_nextBeatCnt = r_beatCnt;
        case (r_state)
            IDLE: begin
                w_nextBeatCnt = '0;
                if (w_anyGnt && w_gntLock && BURST_ALLOWED) begin
                    w_nextState   = (w_gntId == REQ_ENG) ? OWN1 : OWN0;
                    w_nextBeatCnt = CNT_ONE;
                end
            end
            OWN0, OWN1: begin
                if (w_anyGnt && w_gntLock && ((r_beatCnt + CNT_ONE) != CNT_MAX)) begin
                    w_nextBeatCnt = r_beatCnt + CNT_ONE;
                end else begin
                    w_nextState   = IDLE;
                    w_nextBeatCnt = '0;
                end
            end
            default: begin
                w_nextState   = IDLE;
                w_nextBeatCnt = '0;
            end
        endcase
    end

    // Grant decode: contest in IDLE, only the owner may proceed otherwise.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (r0_req && r1_req) begin
                    w_gnt0 = (w_contestId == REQ_HOST);
                    w_gnt1 = (w_contestId == REQ_ENG);
                end else begin
                    w_gnt0 = r0_req;
                    w_gnt1 = r1_req;
                end
            end
            OWN0:    w_gnt0 = r0_req;
            OWN1:    w_gnt1 = r1_req;
            default: ;
        endcase
    end

    assign r0_gnt     = w_gnt0;
    assign r1_gnt     = w_gnt1;
    assign w_anyGnt   = w_gnt0 | w_gnt1;
    assign w_gntId    = w_gnt1 ? REQ_ENG : REQ_HOST;
    assign w_gntLock  = w_gnt1 ? r1_lock  : r0_lock;
    assign w_gntWe    = w_gnt1 ? r1_we    : r0_we;
    assign w_gntAddr  = w_gnt1 ? r1_addr  : r0_addr;
    assign w_gntWdata = w_gnt1 ? r1_wdata : r0_wdata;

    // Register the granted beat onto the BRAM port; address/data hold when idle.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            r_portId   <= REQ_HOST;
        end else begin
            bram_en  <= w_anyGnt;
            bram_we  <= w_anyGnt & w_gntWe;
            r_portId <= w_gntId;
            if (w_anyGnt) begin
                bram_addr  <= w_gntAddr;
                bram_wdata <= w_gntWdata;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_rdTagPipe (
        .clk         (clk),
        .reset_in    (reset_in),
        .i_push      (bram_en & ~bram_we),
        .i_pushId    (r_portId),
        .o_headValid (w_headValid),
        .o_tailValid (w_tagValid),
        .o_tailId    (w_tagId)
    );

    assign bram_regce = (READ_LAT == 2) ? w_headValid : 1'b0;
    assign r0_rvalid  = w_tagValid && (w_tagId == REQ_HOST);
    assign r1_rvalid  = w_tagValid && (w_tagId == REQ_ENG);
    assign r0_rdata   = bram_rdata;
    assign r1_rdata   = bram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed table, corner sequences and randomized
// traffic for bram_port_arbiter, checked against a request-level model.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;
    localparam int READ_LAT  = 1;
    localparam int MAX_BURST = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_in;
    logic              r0_req, r0_we, r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r1_req, r1_we, r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic              bram_en, bram_we, bram_regce;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .READ_LAT  (READ_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_lock    (r0_lock),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_lock    (r1_lock),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r0_gnt     (r0_gnt),
        .r1_gnt     (r1_gnt),
        .r0_rvalid  (r0_rvalid),
        .r1_rvalid  (r1_rvalid),
        .r0_rdata   (r0_rdata),
        .r1_rdata   (r1_rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_regce (bram_regce),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    // Initial BRAM contents; 0x080 holds the single-read test byte.
    function automatic logic [7:0] initByte(input int a);
        if (a == 'h080) return 8'h5A;
        return 8'((a * 13 + 7) & 255);
    endfunction

    logic [7:0] bramMem [4096];
    logic [7:0] rdStage1, rdStage2;
    logic       loadMem;

    // Behavioural BRAM with optional output register.
    always @(posedge clk) begin
        if (loadMem) begin
            for (int a = 0; a < 4096; a++) bramMem[a] <= initByte(a);
        end else begin
            if (bram_en) begin
                if (bram_we) bramMem[bram_addr] <= bram_wdata;
                else         rdStage1 <= bramMem[bram_addr];
            end
            if (bram_regce) rdStage2 <= rdStage1;
        end
    end

    assign bram_rdata = (READ_LAT == 2) ? rdStage2 : rdStage1;

    typedef struct {
        logic       req0, we0, lock0;
        logic [11:0] addr0;
        logic [7:0] wdata0;
        logic       req1, we1, lock1;
        logic [11:0] addr1;
        logic [7:0] wdata1;
        logic       expG0, expG1;
    } stimVec_t;

    typedef struct {
        int         due;
        bit         id;
        logic [7:0] data;
    } rdExp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          mOwner;
    int          mBeats;
    int          mLast;
    logic        expEn, expWe;
    logic [11:0] expAddr;
    logic [7:0]  expWdata;
    logic        prevRead1, prevRead2;
    rdExp_t      expQ[$];
    logic [7:0]  shadow [4096];
    stimVec_t    vecs[$];

    function automatic stimVec_t mkVec(input logic q0, input logic w0, input logic l0,
                                       input int a0, input int d0,
                                       input logic q1, input logic w1, input logic l1,
                                       input int a1, input int d1,
                                       input logic e0, input logic e1);
        stimVec_t v;
        v.req0 = q0; v.we0 = w0; v.lock0 = l0; v.addr0 = 12'(a0); v.wdata0 = 8'(d0);
        v.req1 = q1; v.we1 = w1; v.lock1 = l1; v.addr1 = 12'(a1); v.wdata1 = 8'(d1);
        v.expG0 = e0; v.expG1 = e1;
        return v;
    endfunction

    function automatic stimVec_t idleVec();
        return mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stimVec_t randVec(input bit heavy);
        stimVec_t v;
        v.req0   = heavy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
        v.we0    = 1'($urandom_range(0, 1));
        v.lock0  = heavy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        v.addr0  = 12'($urandom_range(0, 31));
        v.wdata0 = 8'($urandom_range(0, 255));
        v.req1   = heavy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
        v.we1    = 1'($urandom_range(0, 1));
        v.lock1  = heavy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        v.addr1  = 12'($urandom_range(0, 31));
        v.wdata1 = 8'($urandom_range(0, 255));
        v.expG0  = 1'b0;
        v.expG1  = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        cyc       = 0;
        mOwner    = -1;
        mBeats    = 0;
        mLast     = 1;
        expEn     = 1'b0;
        expWe     = 1'b0;
        expAddr   = '0;
        expWdata  = '0;
        prevRead1 = 1'b0;
        prevRead2 = 1'b0;
        expQ.delete();
    endtask

    // Reference model: decide this cycle's winner from the ownership rules,
    // compare every DUT output, then advance the model by one cycle.
    task automatic modelStep();
        int          winner;
        logic        lk, wr, dueNow, expRv0, expRv1;
        logic [11:0] ad;
        logic [7:0]  wd;
        winner = -1;
        if (mOwner < 0) begin
            if (r0_req && r1_req) winner = RR ? (1 - mLast) : 0;
            else if (r0_req)      winner = 0;
            else if (r1_req)      winner = 1;
        end else if (mOwner == 0) begin
            if (r0_req) winner = 0;
        end else begin
            if (r1_req) winner = 1;
        end
        checkOutput("grant", 64'({r1_gnt, r0_gnt}), 64'({winner == 1, winner == 0}));
        checkOutput("bramPort", 64'({bram_en, bram_we, bram_addr, bram_wdata}),
                    64'({expEn, expWe, expAddr, expWdata}));
        checkOutput("regce", 64'(bram_regce), 64'((READ_LAT == 2) && prevRead2));
        dueNow = 1'b0;
        if (expQ.size() > 0) dueNow = (expQ[0].due == cyc);
        expRv0 = dueNow && (expQ[0].id == 1'b0);
        expRv1 = dueNow && (expQ[0].id == 1'b1);
        checkOutput("rvalid", 64'({r1_rvalid, r0_rvalid}), 64'({expRv1, expRv0}));
        if (dueNow) begin
            checkOutput("rdata", 64'(expRv1 ? r1_rdata : r0_rdata), 64'(expQ[0].data));
            void'(expQ.pop_front());
        end
        prevRead2 = prevRead1;
        prevRead1 = 1'b0;
        expEn     = (winner >= 0);
        expWe     = 1'b0;
        if (winner >= 0) begin
            lk = (winner == 1) ? r1_lock  : r0_lock;
            wr = (winner == 1) ? r1_we    : r0_we;
            ad = (winner == 1) ? r1_addr  : r0_addr;
            wd = (winner == 1) ? r1_wdata : r0_wdata;
            mBeats   = (mOwner < 0) ? 1 : mBeats + 1;
            mOwner   = (lk && mBeats < MAX_BURST) ? winner : -1;
            mLast    = winner;
            expWe    = wr;
            expAddr  = ad;
            expWdata = wd;
            if (wr) begin
                shadow[ad] = wd;
            end else begin
                expQ.push_back('{cyc + 1 + READ_LAT, 1'(winner), shadow[ad]});
                prevRead1 = 1'b1;
            end
        end else begin
            mOwner = -1;
        end
        cyc++;
    endtask

    task automatic setInputs(input stimVec_t v);
        r0_req = v.req0; r0_we = v.we0; r0_lock = v.lock0; r0_addr = v.addr0; r0_wdata = v.wdata0;
        r1_req = v.req1; r1_we = v.we1; r1_lock = v.lock1; r1_addr = v.addr1; r1_wdata = v.wdata1;
    endtask

    // One cycle: drive after the edge, sample and model-check at negedge.
    task automatic applyStimulus(input stimVec_t v, output logic g0, output logic g1);
        setInputs(v);
        @(negedge clk);
        g0 = r0_gnt;
        g1 = r1_gnt;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic runIdle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) applyStimulus(idleVec(), g0, g1);
    endtask

    task automatic resetDut();
        setInputs(idleVec());
        reset_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic g0, g1, postG0, postG1;
        int   burstR0, burstR1;

        for (int a = 0; a < 4096; a++) shadow[a] = initByte(a);
        modelReset();
        setInputs(idleVec());
        reset_in = 1'b0;
        loadMem  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        loadMem = 1'b0;
        checkOutput("resetPort", 64'({bram_en, bram_we, bram_addr, bram_wdata}), 64'(0));
        checkOutput("resetRvalid", 64'({r1_rvalid, r0_rvalid, bram_regce}), 64'(0));
        @(negedge clk);
        reset_in = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resetPortAfterRelease", 64'({bram_en, bram_we, bram_addr, bram_wdata}), 64'(0));

        $display("[TB] directed vector table");
        vecs.push_back(mkVec(1, 0, 0, 'h010, 0,     1, 0, 0, 'h020, 0,     1, 0));
        vecs.push_back(mkVec(1, 0, 0, 'h011, 0,     1, 0, 0, 'h021, 0,     !RR, RR));
        vecs.push_back(mkVec(1, 0, 0, 'h080, 0,     0, 0, 0, 0, 0,         1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0,         1, 0, 0, 'h040, 0,     0, 1));
        vecs.push_back(mkVec(1, 0, 0, 'h050, 0,     0, 0, 0, 0, 0,         1, 0));
        vecs.push_back(mkVec(1, 1, 1, 'h100, 'hA0,  0, 0, 0, 0, 0,         1, 0));
        vecs.push_back(mkVec(1, 1, 1, 'h101, 'hA1,  1, 0, 0, 'h060, 0,     1, 0));
        vecs.push_back(mkVec(1, 1, 1, 'h102, 'hA2,  1, 0, 0, 'h060, 0,     1, 0));
        vecs.push_back(mkVec(1, 1, 0, 'h103, 'hA3,  1, 0, 0, 'h060, 0,     1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0,         1, 0, 0, 'h060, 0,     0, 1));
        vecs.push_back(mkVec(1, 0, 0, 'h101, 0,     0, 0, 0, 0, 0,         1, 0));
        vecs.push_back(mkVec(1, 0, 0, 'h103, 0,     1, 1, 0, 'h200, 'h77,  !RR, RR));
        vecs.push_back(mkVec(1, 0, 0, 'h102, 0,     0, 0, 0, 0, 0,         1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0,         1, 1, 1, 'h300, 'h33,  0, 1));
        vecs.push_back(mkVec(1, 0, 0, 'h080, 0,     0, 0, 0, 0, 0,         0, 0));
        vecs.push_back(mkVec(1, 0, 0, 'h080, 0,     0, 0, 0, 0, 0,         1, 0));
        vecs.push_back(idleVec());
        vecs.push_back(idleVec());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], g0, g1);
            checkOutput($sformatf("vecGnt[%0d]", i), 64'({g1, g0}), 64'({vecs[i].expG1, vecs[i].expG0}));
        end
        runIdle(3);

        $display("[TB] forced release after MAX_BURST beats");
        resetDut();
        burstR0 = 0;
        burstR1 = 0;
        postG0  = 1'b0;
        postG1  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mkVec(1, 1, 1, 'h400 + i, i + 1, 1, 0, 0, 'h500, 0, 0, 0), g0, g1);
            if (i < 16) begin
                burstR0 += int'(g0);
                burstR1 += int'(g1);
            end
            if (i == 16) begin
                postG0 = g0;
                postG1 = g1;
            end
        end
        checkOutput("forcedBurstR0Beats", 64'(burstR0), 64'(16));
        checkOutput("forcedBurstR1Blocked", 64'(burstR1), 64'(0));
        checkOutput("afterForcedRelease", 64'({postG1, postG0}), 64'(RR ? 2'b10 : 2'b01));
        runIdle(4);

        $display("[TB] reset in the middle of a locked read burst");
        resetDut();
        applyStimulus(mkVec(1, 0, 1, 'h080, 0, 0, 0, 0, 0, 0, 0, 0), g0, g1);
        applyStimulus(mkVec(1, 0, 1, 'h081, 0, 0, 0, 0, 0, 0, 0, 0), g0, g1);
        setInputs(mkVec(1, 0, 1, 'h082, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        reset_in = 1'b0;
        #1;
        checkOutput("midResetPort", 64'({bram_en, bram_we, bram_addr, bram_wdata}), 64'(0));
        checkOutput("midResetRvalid", 64'({r1_rvalid, r0_rvalid, bram_regce}), 64'(0));
        setInputs(idleVec());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        runIdle(4);
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 0, 0, 'h080, 0, 0, 0), g0, g1);
        checkOutput("grantAfterReset", 64'({g1, g0}), 64'(2'b10));
        runIdle(4);

        $display("[TB] randomized traffic");
        resetDut();
        for (int i = 0; i < 500; i++) begin
            applyStimulus(randVec(i >= 300), g0, g1);
        end
        runIdle(4);
        checkOutput("drainedReads", 64'(expQ.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares the single 8-bit BRAM port between two requesters: the host packet controller (requester 0), which services serial write/read commands, and a local processing engine (requester 1). The block grants one access per cycle and registers it onto the BRAM port. It supports locked bursts so a multi-byte packet write or readback is not interleaved. It also returns each read byte to the requester that issued it.

## Interface
- ADDR_W, 12, BRAM address width
- DATA_W, 8, BRAM data width
- READ_LAT, 1, BRAM read latency in cycles from bram_en (1 or 2; 2 when the BRAM output register is used)
- MAX_BURST, 16, maximum locked beats before forced release (≥1)
- clk  in  1  single clock; all logic is on the rising edge
- reset_in  in  1  asynchronous, active-low reset
- r0_req, r1_req  in  1  access request
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_lock, r1_lock  in  1  hold the port after this beat (burst continues)
- r0_addr, r1_addr  in  ADDR_W  access address
- r0_wdata, r1_wdata  in  DATA_W  write data
- r0_gnt, r1_gnt  out  1  combinational; this cycle's request is accepted
- r0_rvalid, r1_rvalid  out  1  read data valid for this requester
- r0_rdata, r1_rdata  out  DATA_W  read data (both driven from bram_rdata)
- bram_en, bram_we  out  1  registered port enable / write enable
- bram_regce  out  1  output-register clock enable (READ_LAT=2 only, else 0)
- bram_addr  out  ADDR_W  registered address
- bram_wdata  out  DATA_W  registered write data
- bram_rdata  in  DATA_W  BRAM read data

## Operation
- Owner FSM has three states:
  - IDLE: no owner.
  - OWN0: requester 0 holds the port.
  - OWN1: requester 1 holds the port.
- IDLE behaviour:
  - If exactly one requester has req=1, it wins.
  - If both request, the arbitration policy picks the winner (see Configuration).
  - The winner's gnt is 1 this cycle.
  - If the winner's lock=1, the FSM goes to OWNx and the beat counter is set to 1. Otherwise it stays in IDLE.
- OWNx behaviour:
  - Only x can be granted, and gnt_x = req_x.
  - A granted beat with lock=1 increments the beat counter.
  - A granted beat with lock=0 is the final beat; the FSM returns to IDLE.
  - If req_x=0, the FSM returns to IDLE with no grant.
  - When a granted beat brings the counter to MAX_BURST, the FSM returns to IDLE regardless of lock (forced release).
- Granted beat: the request fields are captured into bram_en=1, bram_we, bram_addr and bram_wdata on the next edge. With no grant, bram_en=0 and bram_we=0; the other port fields hold.
- Reads: each granted read pushes {valid, id} into a READ_LAT-deep tag pipe. When the pipe output is valid, rvalid of the tagged requester is asserted with rdata = bram_rdata. Writes push no tag.
- Reads and writes pipeline back-to-back with no bubbles. A read of an address written in the previous beat returns the BRAM's write-mode result; the arbiter adds no forwarding.
- gnt is never 1 while the corresponding req=0. At most one gnt is 1 per cycle.

## Timing
- Request accepted in cycle t → bram_* valid in t+1 → rvalid/rdata in t+1+READ_LAT.
- With READ_LAT=2, bram_regce is asserted in t+2 for a read issued in t.
- Sustained throughput is 1 access per cycle. Handover between requesters costs no idle cycle.
- Reset values:
  - Owner state = IDLE, beat counter = 0.
  - Tag pipe cleared.
  - bram_en, bram_we and bram_regce = 0; bram_addr and bram_wdata = 0.
  - Both rvalid = 0.
  - Round-robin pointer set so requester 0 wins the first contest.
- Reset asserted mid-burst or with reads in flight: all state is cleared asynchronously, in-flight reads are dropped and no rvalid is produced.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - An IDLE contest goes to the requester not granted most recently.
  - The pointer updates on every granted beat.
  - After a forced release, the other requester wins if it is requesting.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; requester 0 always wins an IDLE contest.
  - After a forced release, requester 0 may immediately re-acquire the port.

## Structure
- Package bram_arb_pkg holds:
  - Owner state enum (IDLE/OWN0/OWN1).
  - Requester-id constants REQ_HOST=0 and REQ_ENG=1.
  - Default ADDR_W and DATA_W.
- Sub-module rd_tag_pipe: READ_LAT-stage shift register of {valid, id}, with asynchronous clear on reset_in.

## Test plan
- Single read: r0 reads 0x080 with BRAM[0x080]=0x5A → r0_gnt same cycle, bram_addr=0x080 next cycle, r0_rvalid with 0x5A at t+1+READ_LAT; r1_rvalid stays 0.
- Contest: both request reads in IDLE → r0 granted first. With ARB_ROUND_ROBIN_EN, r1 is granted the next cycle. Without it, r1 is granted only once r0_req drops.
- Locked burst: r0 writes 4 beats at 0x100..0x103 with lock=1,1,1,0 while r1_req=1 → r1_gnt=0 for all 4 beats and BRAM holds the 4 bytes; r1 is granted in the cycle after the final beat.
- Forced release: r0 holds lock=1 for 20 beats, MAX_BURST=16 → exactly 16 consecutive r0 grants. Then IDLE: r1 wins with RR enabled; r0 re-acquires with RR disabled.
- Interleaved reads: r0 read, r1 read, r0 read on consecutive cycles → rvalid sequence r0, r1, r0 on consecutive cycles, each with the correct byte.
- Reset mid-burst: reset_in low during beat 3 with a read in flight → all outputs 0 immediately, no rvalid afterwards, owner IDLE; the first request after release is granted normally.
